unified_mem_ctrl: RTL and testbench

Single-port unified instruction/data memory with request arbitration, sitting directly below the multi-cycle RV32I core. It serves the core's instruction-fetch and data-access strobes from one synchronous SRAM array with 1-cycle read latency and byte-lane writes, and maintains access statistics. A one-entry deferral slot absorbs the case where both ports request in the same cycle.

---
 rtl/unified_mem_ctrl_if.sv | 27 ++
 rtl/unified_mem_ctrl.sv | 123 ++++++++++++
 tb/tb_unified_mem_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/unified_mem_ctrl_if.sv
// Request/response bundle between the RV32I core and the unified memory controller.
// The core side drives strobes, addresses and store data; the controller returns read data and statistics.
interface unified_mem_ctrl_if;
  logic        instr_read;
  logic [31:0] instr_addr;
  logic [31:0] instr_out;
  logic        data_read;
  logic [3:0]  data_write;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] fetch_cnt;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
  logic [15:0] conflict_cnt;
  logic [1:0]  mem_err;

  modport master (
    output instr_read, instr_addr, data_read, data_write, data_addr, data_in,
    input  instr_out, data_out, fetch_cnt, load_cnt, store_cnt, conflict_cnt, mem_err
  );

  modport slave (
    input  instr_read, instr_addr, data_read, data_write, data_addr, data_in,
    output instr_out, data_out, fetch_cnt, load_cnt, store_cnt, conflict_cnt, mem_err
  );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Single-port unified I/D memory: one access per edge, one-entry deferral slot, access statistics.
// Optional MEM_ERRCHK_EN adds range/alignment checking and the mem_err[0] sticky flag.
module unified_mem_ctrl #(
  parameter int DEPTH_WORDS = 16384,
  parameter int AW          = 14
) (
  input logic clk,
  input logic rst,
  unified_mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {OP_NONE, OP_FETCH, OP_LOAD, OP_STORE} op_e;
  typedef struct packed {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } acc_t;
  typedef enum logic {IDLE, DEFER} state_e;

  state_e      state;
  acc_t        slot;
  acc_t        data_req, fetch_req, srv, cap;
  logic        drop, acc_err;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] instr_out_q, data_out_q, fetch_cnt_q, load_cnt_q, store_cnt_q;
  logic [15:0] conflict_cnt_q;
  logic [1:0]  mem_err_q;

  // Pick the access served this edge and the (at most one) request parked in the slot.
  always_comb begin
    data_req = '0;
    if (|bus.data_write)
      data_req = '{op: OP_STORE, addr: bus.data_addr, wdata: bus.data_in, we: bus.data_write};
    else if (bus.data_read)
      data_req = '{op: OP_LOAD, addr: bus.data_addr, wdata: 32'h0, we: 4'h0};
    fetch_req = '0;
    if (bus.instr_read)
      fetch_req = '{op: OP_FETCH, addr: bus.instr_addr, wdata: 32'h0, we: 4'h0};

    srv  = '0;
    cap  = '0;
    drop = 1'b0;
    if (state == DEFER) begin
      // Slot wins the edge; it frees, so one new request can take its place.
      srv = slot;
      if (data_req.op != OP_NONE) begin
        cap  = data_req;
        drop = (fetch_req.op != OP_NONE);
      end else begin
        cap = fetch_req;
      end
    end else if (data_req.op != OP_NONE) begin
      srv = data_req;
      cap = fetch_req;
    end else begin
      srv = fetch_req;
    end
  end

  assign idx = srv.addr[AW+1:2];

`ifdef MEM_ERRCHK_EN
  assign acc_err = (srv.op != OP_NONE) &&
                   (((srv.addr >> (AW + 2)) != 32'h0) ||
                    (((srv.op == OP_FETCH) || (srv.op == OP_STORE && srv.we == 4'hF)) &&
                     (srv.addr[1:0] != 2'b00)));
`else
  // Upper bits wrap away and sub-word offset is irrelevant to a full-word access.
  logic unused_addr_bits;
  assign acc_err          = 1'b0;
  assign unused_addr_bits = ^{srv.addr[31:AW+2], srv.addr[1:0]};
`endif

  assign rd_word = acc_err ? 32'h0 : mem[idx];

  always_ff @(posedge clk) begin
    if (!rst && srv.op == OP_STORE && !acc_err)
      for (int k = 0; k < 4; k++)
        if (srv.we[k]) mem[idx][8*k +: 8] <= srv.wdata[8*k +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      slot           <= '0;
      instr_out_q    <= '0;
      data_out_q     <= '0;
      fetch_cnt_q    <= '0;
      load_cnt_q     <= '0;
      store_cnt_q    <= '0;
      conflict_cnt_q <= '0;
      mem_err_q      <= '0;
    end else begin
      case (srv.op)
        OP_FETCH: begin instr_out_q <= rd_word; fetch_cnt_q <= fetch_cnt_q + 32'd1; end
        OP_LOAD:  begin data_out_q  <= rd_word; load_cnt_q  <= load_cnt_q  + 32'd1; end
        OP_STORE: if (!acc_err) store_cnt_q <= store_cnt_q + 32'd1;
        default: ;
      endcase
      case (state)
        IDLE:  if (cap.op != OP_NONE) state <= DEFER;
        DEFER: if (cap.op == OP_NONE) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (cap.op != OP_NONE) begin
        slot <= cap;
        if (conflict_cnt_q != 16'hFFFF) conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
      mem_err_q <= mem_err_q | {drop, acc_err};
    end
  end

  assign bus.instr_out    = instr_out_q;
  assign bus.data_out     = data_out_q;
  assign bus.fetch_cnt    = fetch_cnt_q;
  assign bus.load_cnt     = load_cnt_q;
  assign bus.store_cnt    = store_cnt_q;
  assign bus.conflict_cnt = conflict_cnt_q;
  assign bus.mem_err      = mem_err_q;
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl: single-access vector table, then hand sequences
// for fetch/load conflicts, slot overflow and reset during deferral.
module tb_unified_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unified_mem_ctrl_if bus();
  unified_mem_ctrl #(.DEPTH_WORDS(16384), .AW(14)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [3:0]  dw;
    logic [31:0] da;
    logic [31:0] di;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } vec_t;
  vec_t vecs[10];

`ifdef MEM_ERRCHK_EN
  localparam logic [31:0] WRAP_LOAD = 32'h0;
  localparam logic [1:0]  ERR0      = 2'b01;
`else
  localparam logic [31:0] WRAP_LOAD = 32'h00500093;
  localparam logic [1:0]  ERR0      = 2'b00;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] di);
    bus.instr_read = ir; bus.instr_addr = ia;
    bus.data_read  = dr; bus.data_write = dw;
    bus.data_addr  = da; bus.data_in    = di;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".instr_out"},    bus.instr_out, 32'h0);
    chk({tag, ".data_out"},     bus.data_out, 32'h0);
    chk({tag, ".fetch_cnt"},    bus.fetch_cnt, 32'h0);
    chk({tag, ".load_cnt"},     bus.load_cnt, 32'h0);
    chk({tag, ".store_cnt"},    bus.store_cnt, 32'h0);
    chk({tag, ".conflict_cnt"}, {16'h0, bus.conflict_cnt}, 32'h0);
    chk({tag, ".mem_err"},      {30'h0, bus.mem_err}, 32'h0);
  endtask

  initial begin
    //           ir    ia          dr    dw     da           di            exp_i         exp_d
    vecs[0] = '{1'b0, 32'h0,     1'b0, 4'hF, 32'h0,       32'h00500093, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 32'h0,     1'b0, 4'hF, 32'h104,     32'h11223344, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 32'h0,     1'b0, 4'h0, 32'h0,       32'h0,        32'h00500093, 32'h0};
    vecs[3] = '{1'b0, 32'h0,     1'b1, 4'h4, 32'h104,     32'h00AB0000, 32'h00500093, 32'h0};
    vecs[4] = '{1'b0, 32'h0,     1'b1, 4'h0, 32'h104,     32'h0,        32'h00500093, 32'h11AB3344};
    vecs[5] = '{1'b0, 32'h0,     1'b0, 4'hF, 32'h8,       32'hCAFEF00D, 32'h00500093, 32'h11AB3344};
    vecs[6] = '{1'b0, 32'h0,     1'b0, 4'h3, 32'h8,       32'h1234BEEF, 32'h00500093, 32'h11AB3344};
    vecs[7] = '{1'b0, 32'h0,     1'b1, 4'h0, 32'h8,       32'h0,        32'h00500093, 32'hCAFEBEEF};
    vecs[8] = '{1'b0, 32'h0,     1'b1, 4'h0, 32'h10000,   32'h0,        32'h00500093, WRAP_LOAD};
    vecs[9] = '{1'b1, 32'h104,   1'b0, 4'h0, 32'h0,       32'h0,        32'h11AB3344, WRAP_LOAD};

    rst = 1'b1;
    idle();
    step(); step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Back-to-back single accesses; vector 3 also checks load is ignored under a store.
    foreach (vecs[i]) begin
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].di);
      step();
      chk($sformatf("vec%0d.instr_out", i), bus.instr_out, vecs[i].exp_i);
      chk($sformatf("vec%0d.data_out", i),  bus.data_out,  vecs[i].exp_d);
    end
    idle();
    chk("vec.fetch_cnt", bus.fetch_cnt, 32'd2);
    chk("vec.load_cnt",  bus.load_cnt,  32'd3);
    chk("vec.store_cnt", bus.store_cnt, 32'd5);
    chk("vec.conflict",  {16'h0, bus.conflict_cnt}, 32'd0);
    chk("vec.mem_err",   {30'h0, bus.mem_err}, {30'h0, ERR0});

    // A: simultaneous fetch+load, fetch deferred one edge
    drive(1'b1, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
    step(); idle();
    chk("A.data_first",   bus.data_out,  32'hCAFEBEEF);
    chk("A.instr_held",   bus.instr_out, 32'h11AB3344);
    step();
    chk("A.instr_later",  bus.instr_out, 32'h00500093);
    chk("A.conflict",     {16'h0, bus.conflict_cnt}, 32'd1);

    // B: slot full, new load captured as the slot drains
    drive(1'b1, 32'h104, 1'b1, 4'h0, 32'h0, 32'h0);
    step();
    chk("B.data1", bus.data_out, 32'h00500093);
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h104, 32'h0);
    step(); idle();
    chk("B.instr", bus.instr_out, 32'h11AB3344);
    step();
    chk("B.data2",    bus.data_out, 32'h11AB3344);
    chk("B.conflict", {16'h0, bus.conflict_cnt}, 32'd3);
    chk("B.mem_err",  {30'h0, bus.mem_err}, {30'h0, ERR0});

    // C: two new requests while slot full -> one captured, fetch dropped
    drive(1'b1, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
    step();
    chk("C.data1", bus.data_out, 32'hCAFEBEEF);
    drive(1'b1, 32'h104, 1'b1, 4'h0, 32'h104, 32'h0);
    step(); idle();
    chk("C.instr",   bus.instr_out, 32'h00500093);
    chk("C.mem_err", {30'h0, bus.mem_err}, {30'h0, 1'b1, ERR0[0]});
    step();
    chk("C.data2", bus.data_out, 32'h11AB3344);
    step();
    chk("C.no_dropped_fetch", bus.instr_out, 32'h00500093);
    chk("C.conflict",  {16'h0, bus.conflict_cnt}, 32'd5);
    chk("C.fetch_cnt", bus.fetch_cnt, 32'd5);
    chk("C.load_cnt",  bus.load_cnt,  32'd8);
    chk("C.store_cnt", bus.store_cnt, 32'd5);

    // D: reset while a fetch sits in the slot
    drive(1'b1, 32'h104, 1'b1, 4'h0, 32'h0, 32'h0);
    step(); idle();
    chk("D.data_pre", bus.data_out, 32'h00500093);
    #1 rst = 1'b1;
    #2 chk_zero("D.async");
    step();
    rst = 1'b0;
    step(); step();
    chk_zero("D.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
